seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Consumer of the 32-bit counter's divided clock output `NewClk`.
- Turns each rising edge of `NewClk` into a one-cycle scan enable in the `clk` domain, so `NewClk` is never used as a clock.
- Time-multiplexes a hex value onto the board's common-anode seven-segment display, one digit per enable.
- Sits between the clock-divider stage and the board pins, displaying a debug value such as PC or ALU result.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- BLANK_LZ, 1, 1 = leading-zero blanking enabled; digit 0 is never blanked.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- NewClk  in  1  divided clock from the counter stage; sampled as data in the `clk` domain.
- value  in  4*DIGITS  hex value to display; nibble i maps to digit i (digit 0 is rightmost).
- dp_in  in  DIGITS  decimal-point request per digit, 1 = lit.
- an  out  DIGITS  anode selects, active-low, one-hot-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse when digit 0 is driven, i.e. a new frame starts.

Behaviour:
- Clocking and reset:
  - One clock, `clk`; every flop updates on `posedge clk`.
  - `rst` is synchronous, active-high.
  - All outputs are registered.
- Reset values:
  - `an` = all 1s, `seg` = 7'h7F, `dp` = 1, `frame_done` = 0.
  - `nclk_d` = 0, `idx` = DIGITS-1, `frame_val` = 0, `frame_dp` = 0.
- Edge detect:
  - `step = NewClk & ~nclk_d`, where `nclk_d` is `NewClk` delayed one `clk`.
  - `NewClk` held high produces exactly one step.
  - `NewClk` high while `rst` is asserted produces no step; `nclk_d` is forced to 0. A `NewClk` still high on the first post-reset cycle therefore gives a step on that cycle.
- Scan counter:
  - On `step`: `idx_next` = 0 if `idx` == DIGITS-1, else `idx`+1.
  - Without `step`, `idx` and all outputs hold.
- Frame snapshot:
  - On a `step` that wraps to 0: `frame_val` <= `value` and `frame_dp` <= `dp_in`.
  - The digit-0 output in that same update uses the incoming `value`/`dp_in` (bypass), not the stale frame registers.
  - `value` changes mid-frame do not appear until the next wrap, so there is no tearing.
  - Because `idx` resets to DIGITS-1, the first step after reset wraps, snapshots and drives digit 0.
- Output update (same edge as `step` is seen, so 1 `clk` after the `NewClk` rise is sampled):
  - `an`: bit `idx_next` = 0, others 1.
  - `nib = src[4*idx_next +: 4]`, where `src` is the bypassed value on a wrap step and `frame_val` otherwise.
  - `seg` = ~hex7(`nib`); `dp` = ~`src_dp[idx_next]`.
  - `frame_done` = 1 for that single cycle when `idx_next` == 0, else 0.
- Blanking: when BLANK_LZ=1 and `idx_next` != 0 and nibbles `idx_next`..DIGITS-1 of `src` are all zero:
  - `seg` = 7'h7F.
  - `an` is still driven (digit selected but dark), keeping the duty cycle uniform.
  - `dp` still follows `dp_in`.
- Hex table, active-high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Reset mid-scan: outputs go dark on the next edge. Scanning restarts from digit 0, with a fresh snapshot, at the first step after reset release.
- Simultaneous `rst` and `step`: `rst` wins.

Decomposition:
- Shared include `seg7_defs.vh`:
  - `define` constants for the 16 segment codes, SEG_OFF = 7'h7F and AN_OFF.
  - Shared with any future display stage.
- Sub-module `hex_to_seg7`: purely combinational 4-bit to 7-bit active-high decode. It is instantiated once on the selected nibble.
- Top block keeps:
  - edge detect, `idx`, snapshot registers;
  - blanking logic;
  - output registers and polarity inversion.

Test Plan:
- Reset, then NewClk idle: `rst` high 3 cycles, `NewClk`=0 → `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame_done`=0; all stay there with no steps.
- Basic scan: `value`=16'h12AF, BLANK_LZ=1, 4 `NewClk` pulses →
  - `an` sequence 1110/1101/1011/0111;
  - `seg` sequence ~71/~77/~5B/~06 (F, A, 2, 1);
  - `frame_done` high only on the first step's edge.
- Edge detect: `NewClk` held high 20 cycles → exactly one `idx` advance; toggling `NewClk` each cycle → one advance per rising edge.
- Snapshot: `value`=16'h1234, change to 16'hBEEF after the digit-1 step →
  - digits 2,3 show 2,1 (old frame);
  - the next wrap shows F, then E, E, b;
  - no mixed digits within one frame.
- Leading-zero blanking: `value`=16'h0007, `dp_in`=4'b0100 →
  - digit 0 `seg`=~07;
  - digits 1,3 `seg`=7'h7F;
  - digit 2 `seg`=7'h7F with `dp`=0.
  - `value`=0 → digit 0 shows ~3F (0), others blank.
- Mid-scan reset: assert `rst` while digit 2 is displayed, simultaneous with a step → outputs dark next edge; after release, the first step shows digit 0 with `frame_done`=1.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg
// Shared constants for the seven-segment display stages.
// Segment codes are active-high in {g,f,e,d,c,b,a} order. The display pins
// are active-low, so the driver inverts these codes before they reach the board.
// The package holds the codes that the decoder and the scan driver share.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  // Active-low pin value that leaves every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_scan_driver_hex.sv
// hex_to_seg7
// Purely combinational decoder from a 4-bit hex digit to 7-bit segment codes.
// The codes are active-high and use {g,f,e,d,c,b,a} order.
// Ports:
//   nib  in   4  hex digit to decode
//   seg  out  7  active-high segment pattern
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_HEX_0;
    case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_HEX_0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes a hex value onto a common-anode seven-segment display.
// The driver shows one digit for each rising edge of the divided clock NewClk.
// NewClk is only sampled as data in the clk domain.
// A frame snapshot is taken when the scan wraps to digit 0, so a value that
// changes mid-frame never produces a display that mixes old and new digits.
// Ports:
//   clk         in   1         system clock
//   rst         in   1         synchronous reset, active-high
//   NewClk      in   1         divided clock, sampled as data
//   value       in   4*DIGITS  hex value, nibble i -> digit i (0 rightmost)
//   dp_in       in   DIGITS    decimal-point request per digit, 1 = lit
//   an          out  DIGITS    anode selects, active-low one-hot
//   seg         out  7         segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1         decimal point, active-low
//   frame_done  out  1         one-cycle pulse when digit 0 is driven
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  NewClk,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  logic                nclk_d;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_next;
  logic [4*DIGITS-1:0] frame_val;
  logic [DIGITS-1:0]   frame_dp;
  logic                step;
  logic                wrap;
  logic [4*DIGITS-1:0] src;
  logic [DIGITS-1:0]   src_dp;
  logic [3:0]          nib;
  logic [6:0]          hex;
  logic                upper_zero;
  logic                blank;
  logic [DIGITS-1:0]   an_next;

  assign step     = NewClk & ~nclk_d;
  assign wrap     = (idx == LAST_IDX);
  assign idx_next = wrap ? '0 : idx + 1'b1;

  // On a wrap the frame registers still hold the previous frame, so digit 0
  // reads the live inputs directly to show the same snapshot being captured.
  assign src    = wrap ? value : frame_val;
  assign src_dp = wrap ? dp_in : frame_dp;
  assign nib    = src[4*idx_next +: 4];

  // A digit is a leading zero when it and every more-significant nibble are
  // zero. Digit 0 is exempt so that a zero value still shows "0".
  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(idx_next) && src[4*k +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    blank = (BLANK_LZ != 0) && (idx_next != '0) && upper_zero;
  end

  assign an_next = ~(DIGITS'(1) << idx_next);

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (hex)
  );

  // Everything advances only on a scan step. Reset restarts idx at the last
  // digit, so the first step after reset wraps and takes a fresh snapshot.
  // A blanked digit still drives its anode, which keeps brightness uniform.
  always_ff @(posedge clk) begin
    if (rst) begin
      nclk_d     <= 1'b0;
      idx        <= LAST_IDX;
      frame_val  <= '0;
      frame_dp   <= '0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      nclk_d     <= NewClk;
      frame_done <= 1'b0;
      if (step) begin
        idx <= idx_next;
        if (wrap) begin
          frame_val <= value;
          frame_dp  <= dp_in;
        end
        an         <= an_next;
        seg        <= blank ? SEG_OFF : ~hex;
        dp         <= ~src_dp[idx_next];
        frame_done <= (idx_next == '0);
      end
    end
  end

endmodule
